// File: rtl/alu_buffer_fifo.sv
// alu_buffer_fifo: registered successor to the ALU pass-through mode.
// Each accepted operation picks one operand (or its complement), derives the
// N/Z/V/C flags for that result and queues {result, N, Z, V, C, set_flags} in
// a DEPTH-entry FIFO. The architectural NZCV register follows popped entries
// that carry set_flags. Sits between operand fetch and writeback.
module alu_buffer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [2:0]                 select,
  input  logic                       set_flags,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out,
  output logic                       negative,
  output logic                       zero,
  output logic                       overflow,
  output logic                       carry_flag,
  output logic [3:0]                 flags_q,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // Entry layout: [EW-1:5] result, [4] N, [3] Z, [2] V, [1] C, [0] set_flags
  localparam int EW = WIDTH + 5;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       flags_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [WIDTH-1:0] result;
  logic             resultNeg;
  logic             resultZero;
  logic [EW-1:0]    pushEntry;
  logic [EW-1:0]    headEntry;
  logic             pushEn;
  logic             popEn;

  // Operand selection; unused select codes deliberately produce a zero result
  always_comb begin
    result = '0;
    case (select)
      3'b000:  result = B;
      3'b001:  result = A;
      3'b111:  result = ~B;
      default: result = '0;
    endcase
  end

  // Flags for the selected result; a pure pass never overflows or carries
  assign resultNeg  = result[WIDTH-1];
  assign resultZero = (result == '0);
  assign pushEntry  = {result, resultNeg, resultZero, 1'b0, 1'b0, set_flags};

  // Handshake decode straight from the count register, so in_ready never
  // depends on out_ready and a full FIFO refuses a push even while popping
  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign pushEn    = in_valid && in_ready && !flush;
  assign popEn     = out_valid && out_ready && !flush;

  // Head entry is read from registered storage at the read pointer
  assign headEntry  = mem_q[rdPtr_q];
  assign out        = headEntry[EW-1:5];
  assign negative   = headEntry[4];
  assign zero       = headEntry[3];
  assign overflow   = headEntry[2];
  assign carry_flag = headEntry[1];
  assign count      = count_q;

  // Next-state for pointers, occupancy and the architectural flag register;
  // flush wins over any push or pop in the same cycle and freezes flags
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    flags_d = flags_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PW'(1);
        if (headEntry[0]) begin
          flags_d = {headEntry[4], headEntry[3], headEntry[1], headEntry[2]};
        end
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear of all bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      flags_q <= 4'b0000;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= pushEntry;
    end
  end

endmodule

// File: tb/tb_alu_buffer_fifo.sv
// Directed testbench for alu_buffer_fifo (WIDTH=64, DEPTH=4).
module tb_alu_buffer_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       select;
  logic             set_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_flag;
  logic [3:0]       flags_q;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  alu_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .select(select), .set_flags(set_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .negative(negative), .zero(zero), .overflow(overflow),
    .carry_flag(carry_flag), .flags_q(flags_q), .count(count)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one pass-B entry, consumer held off
  task automatic push_b(input logic [WIDTH-1:0] b, input logic sf);
    A = '0; B = b; select = 3'b000; set_flags = sf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 0; out_ready = 0; flush = 0;
    A = '0; B = '0; select = '0; set_flags = 0;
    #1 rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("[TB] FAIL reset flags_q: got %b expected 0000", flags_q); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset count: got %0d expected 0", count); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    A = 64'd4; B = 64'd3; select = 3'b000; set_flags = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pass out_valid: got %b expected 1", out_valid); end
    checks++; if (out !== 64'd3) begin errors++; $display("[TB] FAIL pass out: got %0h expected 3", out); end
    checks++; if ({negative, zero, overflow, carry_flag} !== 4'b0000) begin errors++; $display("[TB] FAIL pass NZVC: got %b expected 0000", {negative, zero, overflow, carry_flag}); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("[TB] FAIL pass flags_q: got %b expected 0000", flags_q); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL pass count: got %0d expected 0", count); end
  endtask

  task automatic test_modes();
    logic [2:0]       sel  [3];
    logic [WIDTH-1:0] expO [3];
    logic [1:0]       expNZ[3];
    sel = '{3'b001, 3'b111, 3'b010};
    expO = '{64'd11, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0};
    expNZ = '{2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      A = 64'd11; B = 64'd9; select = sel[i]; set_flags = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL modes count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out !== expO[i]) begin errors++; $display("[TB] FAIL modes out[%0d]: got %h expected %h", i, out, expO[i]); end
      checks++; if ({negative, zero} !== expNZ[i]) begin errors++; $display("[TB] FAIL modes NZ[%0d]: got %b expected %b", i, {negative, zero}, expNZ[i]); end
      checks++; if ({overflow, carry_flag} !== 2'b00) begin errors++; $display("[TB] FAIL modes VC[%0d]: got %b expected 00", i, {overflow, carry_flag}); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("[TB] FAIL modes flags_q: got %b expected 0000", flags_q); end
  endtask

  task automatic test_full_wrap();
    int expNext;
    int nextB;
    int cycles;
    logic pushing;
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) push_b(WIDTH'(b), 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full in_ready: got %b expected 0", in_ready); end
    // Pop while full and offering B=5: only the pop may happen
    B = 64'd5; select = 3'b000; set_flags = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (out !== 64'd1) begin errors++; $display("[TB] FAIL wrap out: got %0d expected 1", out); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL full-pop count: got %0d expected 3", count); end
    expNext = 2; nextB = 5; cycles = 0;
    while (!(count == 3'd0 && nextB > 9) && cycles < 40) begin
      pushing = in_valid && in_ready;
      if (out_valid) begin
        checks++; if (out !== WIDTH'(expNext)) begin errors++; $display("[TB] FAIL wrap out: got %0d expected %0d", out, expNext); end
        expNext++;
      end
      tick();
      cycles++;
      if (pushing) begin
        nextB++;
        if (nextB > 9) in_valid = 1'b0;
        else B = WIDTH'(nextB);
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (cycles >= 40) begin errors++; $display("[TB] FAIL wrap timeout: got %0d cycles expected below 40", cycles); end
    checks++; if (expNext !== 10) begin errors++; $display("[TB] FAIL wrap popped: got up to %0d expected 9", expNext - 1); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL wrap count: got %0d expected 0", count); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    push_b(64'd20, 1'b0);
    push_b(64'd21, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL simul start count: got %0d expected 2", count); end
    in_valid = 1'b1; out_ready = 1'b1; select = 3'b000;
    for (int i = 0; i < 10; i++) begin
      B = WIDTH'(22 + i);
      checks++; if (out !== WIDTH'(20 + i)) begin errors++; $display("[TB] FAIL simul out: got %0d expected %0d", out, 20 + i); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL simul count: got %0d expected 2", count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out !== WIDTH'(30 + i)) begin errors++; $display("[TB] FAIL simul drain: got %0d expected %0d", out, 30 + i); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL simul end count: got %0d expected 0", count); end
  endtask

  task automatic test_flag_gating();
    push_b(64'h8000_0000_0000_0000, 1'b1);
    push_b(64'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++; if (flags_q !== 4'b1000) begin errors++; $display("[TB] FAIL gating first flags_q: got %b expected 1000", flags_q); end
    tick();
    out_ready = 1'b0;
    checks++; if (flags_q !== 4'b1000) begin errors++; $display("[TB] FAIL gating second flags_q: got %b expected 1000", flags_q); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) push_b(64'd0, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush fill count: got %0d expected 3", count); end
    B = 64'd5; set_flags = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush out_valid: got %b expected 0", out_valid); end
    checks++; if (flags_q !== 4'b1000) begin errors++; $display("[TB] FAIL flush flags_q: got %b expected 1000", flags_q); end
    // After flush the head must be the first new entry
    push_b(64'd55, 1'b0);
    checks++; if (out !== 64'd55) begin errors++; $display("[TB] FAIL flush refill out: got %0d expected 55", out); end
    push_b(64'd0, 1'b1);
    push_b(64'd0, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL refill count: got %0d expected 3", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL async reset count: got %0d expected 0", count); end
    checks++; if (flags_q !== 4'b0000) begin errors++; $display("[TB] FAIL async reset flags_q: got %b expected 0000", flags_q); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async reset handshake: got %b%b expected 10", in_ready, out_valid); end
    tick();
    rst_n = 1'b1;
    push_b(64'd7, 1'b0);
    checks++; if (out !== 64'd7) begin errors++; $display("[TB] FAIL post-reset out: got %0d expected 7", out); end
    checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL post-reset count: got %0d expected 1", count); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_pass_through();
    test_modes();
    test_full_wrap();
    test_simultaneous();
    test_flag_gating();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_buffer_fifo.md
# alu_buffer_fifo

Parametrised, registered successor to the ALU pass-through ("buffer") mode. Each accepted operation selects one operand (or its complement), and the block generates the N/Z/V/C flags for the result. The result and flags go into a DEPTH-entry FIFO with valid/ready handshakes on both sides. An architectural NZCV flag register is updated when a flag-setting entry is popped. The block sits between the operand-fetch stage and writeback in the pipelined datapath.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2)
- DEPTH, 4, FIFO entries (power of two, ≥ 2)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer offers an operation
- in_ready  output  1  block can accept; equals !full
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- select  input  3  mode: 000 pass B, 001 pass A, 111 pass ~B, any other value result 0
- set_flags  input  1  entry updates the flag register when popped
- flush  input  1  synchronous discard of all FIFO entries
- out_valid  output  1  head entry valid; equals !empty
- out_ready  input  1  consumer accepts the head entry
- out  output  WIDTH  head result
- negative, zero, overflow, carry_flag  output  1 each  head entry flags
- flags_q  output  4  architectural {N,Z,C,V} register
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Push occurs when in_valid && in_ready. The stored entry is {result, N, Z, V, C, set_flags}.
- Result is computed combinationally from A, B and select at push time.
- Flag rules per entry:
  - N = result[WIDTH-1]
  - Z = (result == 0)
  - V = 0 and C = 0 for every mode
  - An unused select value therefore stores result 0 with Z=1, N=0.
- Pop occurs when out_valid && out_ready. Entries leave in strict push order.
- If the popped entry has set_flags=1, flags_q <= {N,Z,C,V} of that entry on the same edge. Otherwise flags_q holds its value.
- flush=1:
  - On the next edge, count becomes 0 and the read/write pointers are reset to 0.
  - Push and pop in that cycle are ignored.
  - flags_q is not updated, even if out_ready=1 and the head entry has set_flags=1.
- Full (count==DEPTH): in_ready=0, so no push occurs even if a pop happens in the same cycle. There is no combinational path from out_ready to in_ready.
- Empty (count==0): out_valid=0. out and the flag outputs are don't-care; the verifier must not check them.
- Simultaneous push and pop when 0<count<DEPTH: both happen and count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately to distinguish full from empty.
- Producer rule: A, B, select and set_flags must be stable while in_valid=1 and in_ready=0.
- Consumer guarantee: head outputs are stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n=0), asynchronous and applied immediately:
  - count=0, pointers=0, flags_q=4'b0000
  - out_valid=0, in_ready=1
  - Storage contents are undefined.
- Deassertion of rst_n is synchronized externally. The first push can occur on the first rising edge with rst_n=1.
- Latency: a push at edge t makes the entry visible at the head (out_valid=1, out/flags valid) after edge t when the FIFO was empty. There is no same-cycle bypass.
- flags_q update: visible after the popping edge.
- Throughput: one push and one pop per cycle sustained when not full and not empty.
- Reset asserted mid-operation discards all entries. flags_q returns to 0 regardless of pending set_flags entries.
- All outputs are driven by registers or by the registered head entry, except in_ready and out_valid, which decode the count register.

## Test plan
- Reset and pass-through:
  - Stimulus: hold rst_n=0, then release; push A=4, B=3, select=000, set_flags=1; pop.
  - Required response: while in reset, out_valid=0, in_ready=1, flags_q=0. After the push, out=3, N=0, Z=0, one cycle later. After the pop, flags_q=0000.
- Modes and zero flag:
  - Stimulus: push A=11, B=9 with select=001, 111 and 010; pop each.
  - Required response:
    - select=001: out=11, N=0.
    - select=111: out=~64'd9 = 0xFFFF_FFFF_FFFF_FFF6, N=1.
    - select=010: out=0, Z=1.
  - V and C are 0 in every case.
- Full and wrap-around:
  - Stimulus: with DEPTH=4, push B=1..4 with out_ready=0; then assert out_ready and keep pushing B=5..9.
  - Required response: in_ready=0 at count=4. No push happens in the cycle where count=4 and a pop also occurs. Pop order is 1..9 with no loss or duplication.
- Simultaneous push and pop:
  - Stimulus: at count=2, assert both in_valid and out_ready for 10 cycles.
  - Required response: count stays at 2 and order is preserved.
- Flag register gating:
  - Stimulus: pop entry B=0x8000_0000_0000_0000 with set_flags=1, then pop B=0 with set_flags=0.
  - Required response: flags_q=1000 after the first pop and remains 1000 after the second.
- Flush and mid-operation reset:
  - Stimulus: fill 3 entries and assert flush with in_valid=1 and out_ready=1. Then refill and assert rst_n=0 between clock edges.
  - Required response: after the flush edge, count=0 and flags_q is unchanged. The asynchronous reset clears count and flags_q immediately.
